queue_rf_arb: RTL and testbench
===============================

# queue_rf_arb

Round-robin dequeue scheduler that shares a single output stream between M `queue_rf` instances. Each cycle it selects one non-empty, enabled queue, pops its head entry, and registers that data, with the source queue index, into a one-entry output stage. The output stage uses a valid/accept handshake. The block sits between a bank of per-requester queues and a shared downstream consumer.

## Interface
- `M`, default 4: number of source queues; M ≥ 2, need not be a power of 2.
- `W`, default 32: data width of each queue entry.
- `ID_W`, default `$clog2(M)`: width of the queue index.

- `clk` in 1: clock; all state is updated on the rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `i_en` in M: per-queue enable; bit k = 0 excludes queue k from arbitration.
- `i_empty_w` in M: `o_empty_w` of each queue; bit k = 1 means queue k has no entry this cycle.
- `i_pop_dat` in M*W: `o_pop_dat` of each queue, queue k at bits [k*W +: W]. It is combinational head data, valid in the same cycle as the pop.
- `o_pop` in direction out, width M: one-hot or zero pop strobe to `i_pop` of each queue.
- `o_vld` out 1: output stage holds a valid entry.
- `o_dat` out W: output entry data.
- `o_id` out ID_W: index of the queue that sourced `o_dat`.
- `i_accept` in 1: consumer takes the output entry this cycle. It is only meaningful while `o_vld` = 1.

## Operation
- Eligibility: `elig[k] = i_en[k] & ~i_empty_w[k]`.
- Output slot free: `free = ~o_vld | i_accept`.
- Grant:
  - When `free` and `|elig`, grant exactly one queue k. k is the first eligible index found searching `ptr, ptr+1, …, M-1, 0, …, ptr-1`, modulo M.
  - Otherwise grant none.
- `o_pop[k]` = 1 only for the granted k. It is purely combinational in the grant cycle; at most one bit is ever set.
- Round-robin pointer `ptr`, ID_W bits:
  - On a grant to k, `ptr <= (k == M-1) ? 0 : k+1`.
  - Otherwise `ptr` holds.
  - `ptr` never reaches values ≥ M.
- Output stage, evaluated at the clock edge:
  - Grant to k: `o_vld <= 1`, `o_dat <= i_pop_dat[k]`, `o_id <= k`.
  - No grant and `i_accept`: `o_vld <= 0`. `o_dat` and `o_id` hold.
  - No grant and no accept: all output-stage state holds.
- Simultaneous accept and grant in the same cycle: the old entry is consumed and the new entry is loaded. There is no bubble, so throughput is 1 entry/cycle.
- Backpressure: while `o_vld` = 1 and `i_accept` = 0:
  - `o_pop` = 0.
  - `o_dat` and `o_id` are stable.
  - `o_vld` stays 1.
- `i_accept` while `o_vld` = 0 is ignored.
- `i_en` changes take effect in the same cycle. Disabling a queue never affects an entry already in the output stage.
- Reset values (asserted asynchronously, held while `arst_n` = 0):
  - `o_vld` = 0, `o_dat` = 0, `o_id` = 0, `ptr` = 0.
  - `o_pop` = 0 throughout reset, including gating the combinational path.
  - Reset mid-transfer drops the output entry. Queue contents are the queues' responsibility.
- Simulation assertions, not synthesised:
  - `$onehot0(o_pop)`.
  - No `o_pop[k]` while `i_empty_w[k]`.
  - `o_dat`/`o_id` stable while `o_vld & ~i_accept`.

## Timing
- Latency is 1 cycle:
  - A queue becoming eligible at cycle t with the slot free is popped at t.
  - Its data appears on `o_vld`/`o_dat` at t+1.
- Pop-to-empty feedback: `i_empty_w` at t+1 reflects the pop at t. The block takes no speculative action on it.
- Fairness: with all M queues continuously eligible and `i_accept` tied high, grants rotate 0,1,…,M-1,0. Each queue is served exactly once per M cycles.
- Worst-case wait for an eligible queue with the consumer always accepting: M-1 grants to other queues.

## Test plan
- Reset/idle:
  - Stimulus: assert `arst_n` = 0 mid-run with `o_vld` = 1.
  - Required: `o_vld`/`o_dat`/`o_id` = 0 immediately, `o_pop` = 0. After release with all queues empty, no `o_pop` for 10 cycles.
- Single source (M=4):
  - Stimulus: only queue 2 holds 3 entries A,B,C; `i_accept` = 1.
  - Required: `o_pop` = 4'b0100 for 3 consecutive cycles; outputs A,B,C with `o_id` = 2 on back-to-back cycles; then `o_vld` = 0.
- Round-robin wrap:
  - Stimulus: all 4 queues non-empty and enabled, `i_accept` = 1 for 8 cycles.
  - Required: `o_id` sequence 0,1,2,3,0,1,2,3. With queue 1 disabled the sequence is 0,2,3,0.
- Backpressure:
  - Stimulus: hold `i_accept` = 0 for 5 cycles with `o_vld` = 1, then raise it.
  - Required: `o_pop` = 0, and `o_dat`/`o_id` stable for the 5 cycles. On the accept cycle a new pop occurs and the next entry is registered without a bubble.
- Pointer skip:
  - Stimulus: `ptr` = 3 with only queues 1 and 3 eligible.
  - Required: grant order 3 then 1, with `ptr` going 0 then 2.
- Non-power-of-2 M=3:
  - Stimulus: all queues eligible.
  - Required: `o_id` sequence 0,1,2,0; `ptr` never equals 3.

Source files
------------

// File: rtl/queue_rf_arb.sv
// Round-robin dequeue scheduler: picks one eligible queue per cycle, pops its
// head and registers {data, source id} into a one-entry valid/accept output stage.
module queue_rf_arb #(
  parameter int M    = 4,
  parameter int W    = 32,
  parameter int ID_W = $clog2(M)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [M-1:0]    i_en,
  input  logic [M-1:0]    i_empty_w,
  input  logic [M*W-1:0]  i_pop_dat,
  output logic [M-1:0]    o_pop,
  output logic            o_vld,
  output logic [W-1:0]    o_dat,
  output logic [ID_W-1:0] o_id,
  input  logic            i_accept
);

  localparam logic [ID_W-1:0] LAST = ID_W'(M-1);

  logic [ID_W-1:0]       ptr;
  logic [M-1:0]          elig;
  logic [M-1:0]          gnt_oh;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_id;
  logic                  free;
  logic [M-1:0][W-1:0]   dat_a;

  assign dat_a = i_pop_dat;
  assign free  = ~o_vld | i_accept;

  // ptr + i never exceeds 2M-2, so one conditional subtract replaces a modulo
  function automatic logic [ID_W-1:0] wrap(input int a);
    return (a >= M) ? ID_W'(a - M) : ID_W'(a);
  endfunction

  // Per-queue eligibility and pop strobe; pop is gated by reset so nothing
  // reaches the queues while arst_n is low, even through the comb path.
  for (genvar k = 0; k < M; k++) begin : g_lane
    assign elig[k]  = i_en[k] & ~i_empty_w[k];
    assign o_pop[k] = gnt_oh[k] & arst_n;
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < M; i++) begin
      if (!gnt_vld && free && elig[wrap(int'(ptr) + i)]) begin
        gnt_vld = 1'b1;
        gnt_id  = wrap(int'(ptr) + i);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_id == LAST) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // A grant always loads, which also covers accept-and-refill in one cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_vld <= 1'b0;
      o_dat <= '0;
      o_id  <= '0;
    end else if (gnt_vld) begin
      o_vld <= 1'b1;
      o_dat <= dat_a[gnt_id];
      o_id  <= gnt_id;
    end else if (i_accept) begin
      o_vld <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  logic            hold_q;
  logic [W-1:0]    dat_q;
  logic [ID_W-1:0] id_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_q <= 1'b0;
      dat_q  <= '0;
      id_q   <= '0;
    end else begin
      hold_q <= o_vld & ~i_accept;
      dat_q  <= o_dat;
      id_q   <= o_id;
    end
  end

  always @(posedge clk) begin
    if (arst_n) begin
      assert ($onehot0(o_pop));
      assert ((o_pop & i_empty_w) == '0);
      if (hold_q) assert (o_dat == dat_q && o_id == id_q);
    end
  end
`endif

endmodule

// File: tb/tb_queue_rf_arb.sv
// Directed bench for queue_rf_arb: table-driven cycle vectors on an M=4 instance,
// plus hand sequences for mid-run reset and a non-power-of-2 (M=3) instance.
module tb_queue_rf_arb;
  localparam int W = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]     en, empty, pop;
  logic [4*W-1:0] pdat;
  logic           acc, vld;
  logic [W-1:0]   dat;
  logic [1:0]     id;

  logic [2:0]     en3, empty3, pop3;
  logic [3*W-1:0] pdat3;
  logic           acc3, vld3;
  logic [W-1:0]   dat3;
  logic [1:0]     id3;

  queue_rf_arb #(.M(4), .W(W)) dut (
    .clk(clk), .arst_n(arst_n), .i_en(en), .i_empty_w(empty), .i_pop_dat(pdat),
    .o_pop(pop), .o_vld(vld), .o_dat(dat), .o_id(id), .i_accept(acc));

  queue_rf_arb #(.M(3), .W(W)) dut3 (
    .clk(clk), .arst_n(arst_n), .i_en(en3), .i_empty_w(empty3), .i_pop_dat(pdat3),
    .o_pop(pop3), .o_vld(vld3), .o_dat(dat3), .o_id(id3), .i_accept(acc3));

  typedef struct {
    logic [3:0]  en, empty;
    logic [7:0]  tag;
    logic        acc;
    logic [3:0]  pop;
    logic        vld;
    logic [1:0]  id;
    logic [15:0] dat;
    logic [1:0]  ptr;
  } vec_t;

  vec_t tv[27];
  int n_run = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic [3:0] e, logic [3:0] m, logic [7:0] t, logic a,
                              logic [3:0] p, logic v, logic [1:0] i, logic [15:0] d,
                              logic [1:0] pt);
    vec_t r;
    r.en = e; r.empty = m; r.tag = t; r.acc = a;
    r.pop = p; r.vld = v; r.id = i; r.dat = d; r.ptr = pt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // queue k head data = {tag, k}
  task automatic drive(input logic [3:0] e, input logic [3:0] m, input logic [7:0] t,
                       input logic a);
    en = e; empty = m; acc = a;
    for (int k = 0; k < 4; k++) pdat[k*W +: W] = {t, 8'(k)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            en    empty tag   acc pop     vld id  dat       ptr
    tv[0]  = mk(4'hF, 4'h0, 8'h10, 1, 4'b0001, 1, 0, 16'h1000, 1);
    tv[1]  = mk(4'hF, 4'h0, 8'h11, 1, 4'b0010, 1, 1, 16'h1101, 2);
    tv[2]  = mk(4'hF, 4'h0, 8'h12, 1, 4'b0100, 1, 2, 16'h1202, 3);
    tv[3]  = mk(4'hF, 4'h0, 8'h13, 1, 4'b1000, 1, 3, 16'h1303, 0);
    tv[4]  = mk(4'hF, 4'h0, 8'h14, 1, 4'b0001, 1, 0, 16'h1400, 1);
    tv[5]  = mk(4'hF, 4'h0, 8'h15, 1, 4'b0010, 1, 1, 16'h1501, 2);
    tv[6]  = mk(4'hF, 4'h0, 8'h16, 1, 4'b0100, 1, 2, 16'h1602, 3);
    tv[7]  = mk(4'hF, 4'h0, 8'h17, 1, 4'b1000, 1, 3, 16'h1703, 0);
    tv[8]  = mk(4'hD, 4'h0, 8'h20, 1, 4'b0001, 1, 0, 16'h2000, 1);
    tv[9]  = mk(4'hD, 4'h0, 8'h21, 1, 4'b0100, 1, 2, 16'h2102, 3);
    tv[10] = mk(4'hD, 4'h0, 8'h22, 1, 4'b1000, 1, 3, 16'h2203, 0);
    tv[11] = mk(4'hD, 4'h0, 8'h23, 1, 4'b0001, 1, 0, 16'h2300, 1);
    tv[12] = mk(4'hF, 4'h0, 8'h30, 0, 4'b0000, 1, 0, 16'h2300, 1);
    tv[13] = mk(4'hF, 4'h0, 8'h31, 0, 4'b0000, 1, 0, 16'h2300, 1);
    tv[14] = mk(4'h0, 4'h0, 8'h32, 0, 4'b0000, 1, 0, 16'h2300, 1);
    tv[15] = mk(4'hF, 4'h0, 8'h33, 0, 4'b0000, 1, 0, 16'h2300, 1);
    tv[16] = mk(4'hF, 4'h0, 8'h34, 0, 4'b0000, 1, 0, 16'h2300, 1);
    tv[17] = mk(4'hF, 4'h0, 8'h40, 1, 4'b0010, 1, 1, 16'h4001, 2);
    tv[18] = mk(4'hF, 4'hF, 8'h41, 1, 4'b0000, 0, 1, 16'h4001, 2);
    tv[19] = mk(4'hF, 4'hF, 8'h42, 1, 4'b0000, 0, 1, 16'h4001, 2);
    tv[20] = mk(4'hF, 4'hB, 8'hA0, 1, 4'b0100, 1, 2, 16'hA002, 3);
    tv[21] = mk(4'hF, 4'hB, 8'hB0, 1, 4'b0100, 1, 2, 16'hB002, 3);
    tv[22] = mk(4'hF, 4'hB, 8'hC0, 1, 4'b0100, 1, 2, 16'hC002, 3);
    tv[23] = mk(4'hF, 4'hF, 8'hD0, 1, 4'b0000, 0, 2, 16'hC002, 3);
    tv[24] = mk(4'hF, 4'h5, 8'h50, 1, 4'b1000, 1, 3, 16'h5003, 0);
    tv[25] = mk(4'hF, 4'h5, 8'h51, 1, 4'b0010, 1, 1, 16'h5101, 2);
    tv[26] = mk(4'hF, 4'h5, 8'h52, 1, 4'b1000, 1, 3, 16'h5203, 0);

    // Eligible inputs during reset: pop must stay gated
    drive(4'hF, 4'h0, 8'h00, 1'b1);
    en3 = 3'h0; empty3 = 3'h7; acc3 = 1'b0;
    pdat3 = {16'h3002, 16'h3001, 16'h3000};
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_vld", 32'(vld), 0);
    chk("reset o_dat", 32'(dat), 0);
    chk("reset o_id",  32'(id), 0);
    chk("reset o_pop", 32'(pop), 0);

    @(negedge clk);
    drive(4'hF, 4'hF, 8'h00, 1'b1);
    arst_n = 1'b1;

    for (int v = 0; v < 27; v++) begin
      @(negedge clk);
      drive(tv[v].en, tv[v].empty, tv[v].tag, tv[v].acc);
      #1;
      chk($sformatf("v%0d o_pop", v), 32'(pop), 32'(tv[v].pop));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d o_vld", v), 32'(vld), 32'(tv[v].vld));
      chk($sformatf("v%0d o_id", v),  32'(id),  32'(tv[v].id));
      chk($sformatf("v%0d o_dat", v), 32'(dat), 32'(tv[v].dat));
      chk($sformatf("v%0d ptr", v),   32'(dut.ptr), 32'(tv[v].ptr));
    end

    // Mid-run reset with a held entry and eligible queues
    @(negedge clk);
    drive(4'hF, 4'h0, 8'h60, 1'b0);
    #1;
    chk("pre-reset o_vld", 32'(vld), 1);
    arst_n = 1'b0;
    #1;
    chk("mid reset o_vld", 32'(vld), 0);
    chk("mid reset o_dat", 32'(dat), 0);
    chk("mid reset o_id",  32'(id), 0);
    chk("mid reset o_pop", 32'(pop), 0);
    chk("mid reset ptr",   32'(dut.ptr), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("held reset o_pop", 32'(pop), 0);
    chk("held reset o_vld", 32'(vld), 0);
    @(negedge clk);
    drive(4'hF, 4'hF, 8'h00, 1'b1);
    arst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d o_pop", c), 32'(pop), 0);
      chk($sformatf("idle%0d o_vld", c), 32'(vld), 0);
    end

    // Non-power-of-2: M=3, all eligible, ids 0,1,2,0 and ptr stays below 3
    begin
      logic [2:0] exp_pop3[4];
      logic [1:0] exp_id3[4];
      logic [1:0] exp_ptr3[4];
      exp_pop3 = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_id3  = '{2'd0, 2'd1, 2'd2, 2'd0};
      exp_ptr3 = '{2'd1, 2'd2, 2'd0, 2'd1};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) begin
          en3 = 3'h7; empty3 = 3'h0; acc3 = 1'b1;
        end
        #1;
        chk($sformatf("m3 c%0d o_pop", i), 32'(pop3), 32'(exp_pop3[i]));
        @(posedge clk);
        #1;
        chk($sformatf("m3 c%0d o_vld", i), 32'(vld3), 1);
        chk($sformatf("m3 c%0d o_id", i),  32'(id3), 32'(exp_id3[i]));
        chk($sformatf("m3 c%0d o_dat", i), 32'(dat3), 32'h3000 + 32'(exp_id3[i]));
        chk($sformatf("m3 c%0d ptr", i),   32'(dut3.ptr), 32'(exp_ptr3[i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
